// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results in one cycle and waits for the data-memory
// response on loads, extending the returned word before the register-file write.
module wb_stage #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_rd_wen,
    input  logic [4:0]       i_rd_waddr,
    input  logic [31:0]      i_alu_result,
    input  logic             i_is_load,
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lo,
    input  logic             i_dmem_rvalid,
    input  logic [31:0]      i_dmem_rdata,
    output logic             o_rd_wen,
    output logic [4:0]       o_rd_waddr,
    output logic [31:0]      o_rd_wdata,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_retire_cnt
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                ld_wen_q;
    logic [REG_AW-1:0]   ld_waddr_q;
    logic [2:0]          ld_funct3_q;
    logic [1:0]          ld_addr_lo_q;

    logic                wb_fire;
    logic                wb_wen;
    logic                wb_wen_raw;
    logic [REG_AW-1:0]   wb_waddr;
    logic [XLEN-1:0]     wb_wdata;

    // Select the addressed byte/halfword lane and extend it according to funct3.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      f3,
                                                 input logic [1:0]      lo,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_valid && i_is_load) state_d = WAIT_LOAD;
            WAIT_LOAD: if (i_dmem_rvalid)        state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Writeback selection: ALU result on a non-load accept, extended load data on response.
    always_comb begin
        o_ready    = (state_q == IDLE);
        wb_fire    = 1'b0;
        wb_wen_raw = 1'b0;
        wb_waddr   = '0;
        wb_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (i_valid && !i_is_load) begin
                    wb_fire    = 1'b1;
                    wb_wen_raw = i_rd_wen;
                    wb_waddr   = i_rd_waddr;
                    wb_wdata   = i_alu_result;
                end
            end
            WAIT_LOAD: begin
                if (i_dmem_rvalid) begin
                    wb_fire    = 1'b1;
                    wb_wen_raw = ld_wen_q;
                    wb_waddr   = ld_waddr_q;
                    wb_wdata   = load_ext(ld_funct3_q, ld_addr_lo_q, i_dmem_rdata);
                end
            end
            default: ;
        endcase
        wb_wen = wb_fire && wb_wen_raw && (wb_waddr != REG_AW'(0));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ld_wen_q     <= 1'b0;
            ld_waddr_q   <= '0;
            ld_funct3_q  <= '0;
            ld_addr_lo_q <= '0;
        end else if (i_valid && o_ready && i_is_load) begin
            ld_wen_q     <= i_rd_wen;
            ld_waddr_q   <= i_rd_waddr;
            ld_funct3_q  <= i_funct3;
            ld_addr_lo_q <= i_addr_lo;
        end
    end

    // Write port keeps its last address/data whenever no write occurs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_wen     <= 1'b0;
            o_rd_waddr   <= '0;
            o_rd_wdata   <= '0;
            o_retire     <= 1'b0;
            o_retire_cnt <= '0;
        end else begin
            o_rd_wen <= wb_wen;
            o_retire <= wb_fire;
            if (wb_wen) begin
                o_rd_waddr <= wb_waddr;
                o_rd_wdata <= wb_wdata;
            end
            if (wb_fire) begin
                o_retire_cnt <= o_retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: scoreboard of expected register-file writes checked on every
// retire pulse, plus directed scenario tasks with their own inline checks.
module tb_wb_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        o_ready4;
    logic        i_rd_wen;
    logic [4:0]  i_rd_waddr;
    logic [31:0] i_alu_result;
    logic        i_is_load;
    logic [2:0]  i_funct3;
    logic [1:0]  i_addr_lo;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_rd_wen;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;
    logic        o_retire;
    logic [31:0] o_retire_cnt;
    logic        o_rd_wen4;
    logic [4:0]  o_rd_waddr4;
    logic [31:0] o_rd_wdata4;
    logic        o_retire4;
    logic [3:0]  o_retire_cnt4;

    typedef struct packed {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    int          n_checks;
    int          n_fail;

    wb_stage #(.CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rd_wen(i_rd_wen), .i_rd_waddr(i_rd_waddr), .i_alu_result(i_alu_result),
        .i_is_load(i_is_load), .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata),
        .o_retire(o_retire), .o_retire_cnt(o_retire_cnt)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready4),
        .i_rd_wen(i_rd_wen), .i_rd_waddr(i_rd_waddr), .i_alu_result(i_alu_result),
        .i_is_load(i_is_load), .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_rd_wen(o_rd_wen4), .o_rd_waddr(o_rd_waddr4), .o_rd_wdata(o_rd_wdata4),
        .o_retire(o_retire4), .o_retire_cnt(o_retire_cnt4)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] sb_w;
        logic [31:0] sh_w;
        sb_w = w >> {lo, 3'b000};
        sh_w = w >> {lo[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{sb_w[7]}}, sb_w[7:0]};
            3'b001:  return {{16{sh_w[15]}}, sh_w[15:0]};
            3'b100:  return sb_w & 32'h0000_00FF;
            3'b101:  return sh_w & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // Scoreboard consumer: every retire pops one expected write.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_retire) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_retire t=%0t wen=%0b addr=%0d data=%h",
                                 $time, o_rd_wen, o_rd_waddr, o_rd_wdata);
                    end else begin
                        e = sb.pop_front();
                        exp_cnt = exp_cnt + 32'd1;
                        if (o_rd_wen !== e.wen ||
                            (e.wen && (o_rd_waddr !== e.addr || o_rd_wdata !== e.data))) begin
                            n_fail++;
                            $display("FAIL sb_write t=%0t got wen=%0b addr=%0d data=%h exp wen=%0b addr=%0d data=%h",
                                     $time, o_rd_wen, o_rd_waddr, o_rd_wdata, e.wen, e.addr, e.data);
                        end
                        if (e.wen) begin
                            last_addr = e.addr;
                            last_data = e.data;
                        end
                        n_checks++;
                        if (o_retire_cnt !== exp_cnt || o_retire_cnt4 !== exp_cnt[3:0]) begin
                            n_fail++;
                            $display("FAIL sb_cnt t=%0t got %0d/%0d exp %0d/%0d", $time,
                                     o_retire_cnt, o_retire_cnt4, exp_cnt, exp_cnt[3:0]);
                        end
                    end
                end else begin
                    n_checks++;
                    if (o_rd_wen !== 1'b0) begin
                        n_fail++;
                        $display("FAIL wen_without_retire t=%0t got %b exp 0", $time, o_rd_wen);
                    end
                end
                if (o_rd_wen !== 1'b1) begin
                    n_checks++;
                    if (o_rd_waddr !== last_addr || o_rd_wdata !== last_data) begin
                        n_fail++;
                        $display("FAIL hold t=%0t got addr=%0d data=%h exp addr=%0d data=%h",
                                 $time, o_rd_waddr, o_rd_wdata, last_addr, last_data);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        sb.delete();
        exp_cnt   = '0;
        last_addr = '0;
        last_data = '0;
        step();
        n_checks++;
        if (o_ready !== 1'b1 || o_rd_wen !== 1'b0 || o_rd_waddr !== 5'd0 ||
            o_rd_wdata !== 32'd0 || o_retire !== 1'b0 || o_retire_cnt !== 32'd0 ||
            o_retire_cnt4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b wen=%b addr=%0d data=%h ret=%b cnt=%0d cnt4=%0d exp 1,0,0,0,0,0,0",
                     o_ready, o_rd_wen, o_rd_waddr, o_rd_wdata, o_retire, o_retire_cnt, o_retire_cnt4);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic issue_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
        i_valid      = 1'b1;
        i_is_load    = 1'b0;
        i_rd_wen     = wen;
        i_rd_waddr   = rd;
        i_alu_result = res;
        i_funct3     = 3'($urandom);
        i_addr_lo    = 2'($urandom);
        sb.push_back('{wen && (rd != 5'd0), rd, res});
        step();
        i_valid      = 1'b0;
        i_alu_result = $urandom;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                              input logic [1:0] lo, input logic [31:0] rdata, input int nwait);
        i_valid    = 1'b1;
        i_is_load  = 1'b1;
        i_rd_wen   = wen;
        i_rd_waddr = rd;
        i_funct3   = f3;
        i_addr_lo  = lo;
        step();
        i_valid    = 1'b0;
        i_rd_wen   = 1'($urandom);
        i_rd_waddr = 5'($urandom);
        i_funct3   = 3'($urandom);
        i_addr_lo  = 2'($urandom);
        for (int i = 0; i < nwait; i++) begin
            n_checks++;
            if (o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL load_wait_ready cycle=%0d got %b exp 0", i, o_ready);
            end
            step();
        end
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = rdata;
        sb.push_back('{wen && (rd != 5'd0), rd, ref_load(f3, lo, rdata)});
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_resp_ready got %b exp 0", o_ready);
        end
        step();
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = $urandom;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_done_ready got %b exp 1", o_ready);
        end
    endtask

    task automatic test_alu();
        test_reset();
        issue_alu(5'd5, 1'b1, 32'hDEAD_BEEF);
        n_checks++;
        if (o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd5 || o_rd_wdata !== 32'hDEAD_BEEF ||
            o_retire !== 1'b1 || o_retire_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL alu_basic got wen=%b addr=%0d data=%h ret=%b cnt=%0d exp 1,5,deadbeef,1,1",
                     o_rd_wen, o_rd_waddr, o_rd_wdata, o_retire, o_retire_cnt);
        end
        step();
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_t  [11] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111, 3'b010,
                                    3'b000, 3'b001, 3'b011, 3'b110, 3'b100};
        logic [1:0]  lo_t  [11] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] rd_t  [11] = '{32'h8011_2233, 32'h8011_2233, 32'h8001_7FFF, 32'h8001_7FFF,
                                    32'h8001_7FFF, 32'h1234_5678, 32'h0000_8000, 32'h1234_ABCD,
                                    32'hCAFE_0001, 32'hF00D_0002, 32'h00A5_0000};
        logic [31:0] ex_t  [11] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF,
                                    32'h8001_7FFF, 32'h1234_5678, 32'hFFFF_FF80, 32'hFFFF_ABCD,
                                    32'hCAFE_0001, 32'hF00D_0002, 32'h0000_00A5};
        for (int i = 0; i < 11; i++) begin
            issue_load(5'd7, 1'b1, f3_t[i], lo_t[i], rd_t[i], (i < 2) ? 3 : (i % 4));
            n_checks++;
            if (o_retire !== 1'b1 || o_rd_wen !== 1'b1 || o_rd_wdata !== ex_t[i]) begin
                n_fail++;
                $display("FAIL load_ext[%0d] got ret=%b wen=%b data=%h exp 1,1,%h",
                         i, o_retire, o_rd_wen, o_rd_wdata, ex_t[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int k = 0; k < 3; k++) begin
            issue_alu(5'(k), 1'b1, 32'h100 + 32'(k));
            i_valid = (k < 2);
            n_checks++;
            if (o_retire !== 1'b1 || o_rd_wen !== (k != 0)) begin
                n_fail++;
                $display("FAIL b2b[%0d] got ret=%b wen=%b exp 1,%b", k, o_retire, o_rd_wen, k != 0);
            end
        end
        step();
        n_checks++;
        if (o_retire !== 1'b0 || o_retire_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL b2b_end got ret=%b cnt=%0d exp 0,3", o_retire, o_retire_cnt);
        end
        issue_load(5'd0, 1'b1, 3'b010, 2'd0, 32'h5555_AAAA, 1);
        issue_load(5'd3, 1'b0, 3'b010, 2'd0, 32'h6666_BBBB, 0);
        step();
    endtask

    task automatic test_rvalid_idle_and_stall();
        i_valid       = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (o_retire !== 1'b0 || o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rvalid_idle[%0d] got ret=%b rdy=%b exp 0,1", i, o_retire, o_ready);
            end
        end
        i_dmem_rvalid = 1'b0;
        i_valid    = 1'b1;
        i_is_load  = 1'b1;
        i_rd_wen   = 1'b1;
        i_rd_waddr = 5'd12;
        i_funct3   = 3'b000;
        i_addr_lo  = 2'd2;
        step();
        i_is_load    = 1'b0;
        i_rd_waddr   = 5'd9;
        i_alu_result = 32'h1111_2222;
        step();
        step();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h0042_0000;
        sb.push_back('{1'b1, 5'd12, 32'h0000_0042});
        step();
        i_dmem_rvalid = 1'b0;
        sb.push_back('{1'b1, 5'd9, 32'h1111_2222});
        step();
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_load();
        test_reset();
        i_valid    = 1'b1;
        i_is_load  = 1'b1;
        i_rd_wen   = 1'b1;
        i_rd_waddr = 5'd4;
        i_funct3   = 3'b010;
        step();
        i_valid = 1'b0;
        step();
        sb.delete();
        exp_cnt = '0;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_ready !== 1'b1 || o_retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset got rdy=%b cnt=%0d exp 1,0", o_ready, o_retire_cnt);
        end
        last_addr = '0;
        last_data = '0;
        step();
        i_rst_n       = 1'b1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h9999_9999;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (o_retire !== 1'b0 || o_rd_wen !== 1'b0 || o_ready !== 1'b1 || o_retire_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_discard[%0d] got ret=%b wen=%b rdy=%b cnt=%0d exp 0,0,1,0",
                         i, o_retire, o_rd_wen, o_ready, o_retire_cnt);
            end
        end
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic test_wrap();
        test_reset();
        for (int k = 0; k < 17; k++) issue_alu(5'd3, 1'b1, 32'(k));
        step();
        n_checks++;
        if (o_retire_cnt4 !== 4'd1 || o_retire_cnt !== 32'd17) begin
            n_fail++;
            $display("FAIL cnt_wrap got cnt4=%0d cnt=%0d exp 1,17", o_retire_cnt4, o_retire_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0)
                issue_alu(5'($urandom), 1'($urandom), $urandom);
            else
                issue_load(5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                           int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) step();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_valid       = 1'b0;
        i_rd_wen      = 1'b0;
        i_rd_waddr    = '0;
        i_alu_result  = '0;
        i_is_load     = 1'b0;
        i_funct3      = '0;
        i_addr_lo     = '0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = '0;
        n_checks      = 0;
        n_fail        = 0;
        exp_cnt       = '0;
        last_addr     = '0;
        last_data     = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_alu();
        test_load_ext();
        drain();
        test_back_to_back();
        drain();
        test_rvalid_idle_and_stall();
        drain();
        test_reset_in_load();
        test_wrap();
        drain();
        test_random();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 SHALL have port i_clk  input  1  global clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-004 SHALL have port i_valid  input  1  MEM stage presents an instruction.
REQ-005 SHALL have port o_ready  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port i_rd_wen  input  1  instruction writes a destination register.
REQ-007 SHALL have port i_rd_waddr  input  5  destination register index.
REQ-008 SHALL have port i_alu_result  input  32  non-load writeback value.
REQ-009 SHALL have port i_is_load  input  1  instruction is a load.
REQ-010 SHALL have port i_funct3  input  3  load type.
REQ-011 SHALL have port i_addr_lo  input  2  load byte address bits [1:0].
REQ-012 SHALL have port i_dmem_rvalid  input  1  data-memory read response valid.
REQ-013 SHALL have port i_dmem_rdata  input  32  data-memory read word.
REQ-014 SHALL have ports o_rd_wen (1), o_rd_waddr (5), o_rd_wdata (32), all outputs, driving the register-file write port.
REQ-015 SHALL have port o_retire  output  1  one-cycle pulse per retired instruction.
REQ-016 SHALL have port o_retire_cnt  output  CNT_W  retired-instruction count.

Function
REQ-017 SHALL implement states IDLE and WAIT_LOAD; o_ready = 1 exactly in IDLE.
REQ-018 SHALL accept an instruction on a cycle where i_valid && o_ready; all instruction inputs are sampled only then.
REQ-019 Non-load accept in IDLE SHALL stay in IDLE and, next cycle, drive o_rd_wdata = i_alu_result with o_rd_wen/o_retire pulsed for one cycle; back-to-back accepts SHALL give back-to-back writes (throughput 1/cycle).
REQ-020 Load accept SHALL transition IDLE -> WAIT_LOAD and latch rd index, rd_wen, funct3, addr_lo.
REQ-021 In WAIT_LOAD, i_dmem_rvalid = 1 SHALL capture i_dmem_rdata, return to IDLE, and drive the extended value with o_rd_wen/o_retire pulsed the next cycle.
REQ-022 i_dmem_rvalid SHALL be ignored in IDLE; response latency from accept is unbounded (min 1 cycle).
REQ-023 Load extension by funct3: 000 LB sign-extend byte addr_lo; 001 LH sign-extend halfword addr_lo[1]; 010 LW whole word; 100 LBU zero-extend byte; 101 LHU zero-extend halfword; 011/110/111 SHALL be treated as LW.
REQ-024 Byte lane n occupies rdata[8n+7:8n]; halfword lane h occupies rdata[16h+15:16h]; addr_lo[0] ignored for halfwords.
REQ-025 o_rd_wen SHALL be asserted only if latched rd_wen = 1 and rd index != 0; o_retire SHALL pulse regardless.
REQ-026 o_rd_waddr/o_rd_wdata SHALL hold their last values when o_rd_wen = 0.
REQ-027 o_retire_cnt SHALL increment by 1 on each o_retire pulse (same edge that asserts the pulse), wrapping modulo 2^CNT_W.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs except none to o_ready.

Reset
REQ-029 While i_rst_n = 0: state IDLE, o_ready = 1, o_rd_wen = 0, o_rd_waddr = 0, o_rd_wdata = 0, o_retire = 0, o_retire_cnt = 0.
REQ-030 Reset asserted in WAIT_LOAD SHALL discard the pending load; a later i_dmem_rvalid SHALL cause no write.
REQ-031 Reset deassertion SHALL take effect at the next rising i_clk; accept possible on that first edge.

Verification
REQ-032 Non-load rd=5, result 0xDEADBEEF accepted -> next cycle o_rd_wen=1, waddr=5, wdata=0xDEADBEEF, o_retire=1, cnt=1.
REQ-033 LB addr_lo=3, rdata=0x80112233 after 3 wait cycles -> o_ready=0 for 3+1 cycles, then wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 LH addr_lo=2, rdata=0x8001_7FFF -> 0xFFFF8001; LHU addr_lo=0 -> 0x00007FFF; funct3=111 -> 0x80017FFF.
REQ-035 Three back-to-back non-loads rd=0,1,2 -> retire pulses 3 consecutive cycles, o_rd_wen only for rd 1 and 2, cnt=3.
REQ-036 Load accepted, i_rst_n low during WAIT_LOAD, then rvalid -> no write, cnt=0, o_ready=1.
REQ-037 CNT_W=4, 17 retirements -> o_retire_cnt=1 (wrap).
